dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
- Shares the single-port data memory between the EX-stage load/store path and the program/data loader port.
- Sequences each access: single-cycle writes, two-cycle reads on a registered-read memory.
- Stalls EX while an access is outstanding or lost to the loader.
- Sits between EX, the loader and data_memory; the memory address is the low 10 bits of the EX operand.

Parameters:
ADDR_W, 10, memory word-address width
DATA_W, 32, data width
STARVE_MAX, 4, loader wait cycles before loader overrides EX priority

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  synchronous active-low reset
ex_req  in  1  EX access request, held until complete
ex_we  in  1  1 = store, 0 = load
ex_addr  in  ADDR_W  EX word address
ex_wdata  in  DATA_W  EX store data
ex_stall  out  1  pipeline stall to EX
ex_rvalid  out  1  EX load data valid
ex_rdata  out  DATA_W  EX load data
ld_req  in  1  loader request, held until ld_gnt
ld_we  in  1  loader store/load
ld_addr  in  ADDR_W  loader address
ld_wdata  in  DATA_W  loader store data
ld_gnt  out  1  loader access issued this cycle
ld_rvalid  out  1  loader load data valid
ld_rdata  out  DATA_W  loader load data
mem_addr  out  ADDR_W  memory address
mem_data  out  DATA_W  memory write data
mem_we  out  1  memory write enable
mem_q  in  DATA_W  memory read data, valid one cycle after its address

Behaviour:
- One clock, CLK. Reset is synchronous and active-low on RST_N; sampled at the rising edge.
- Reset: state IDLE, starve_cnt 0. All outputs 0 except ex_stall = ex_req.
- FSM states: IDLE, RD_EX, RD_LD.
- IDLE winner: EX if ex_req and (!ld_req or starve_cnt < STARVE_MAX); otherwise loader if ld_req. No request means no issue, and all mem_* outputs are 0.
- Issue cycle: mem_addr, mem_data and mem_we = winner's addr, wdata and we, combinationally. ld_gnt=1 if the loader wins.
- Write: completes at the issue edge; stay in IDLE, so back-to-back writes are allowed.
- Read: go to RD_EX or RD_LD. In that state, drive rvalid=1 and rdata=mem_q for the winner, mem_we=0, no new issue, then return to IDLE.
- ex_stall = ex_req & !(EX write issued this cycle) & !ex_rvalid. It is combinational.
- EX load latency: 2 cycles, 1 stall cycle. EX store: 0 stall when uncontested.
- starve_cnt:
  - +1 each cycle ld_req=1 and no loader issue, saturating at STARVE_MAX.
  - Cleared on ld_gnt.
  - Held when ld_req=0.
- rdata outputs are 0 when the matching rvalid=0.
- Request deasserted during RD_*: data still delivered; the requester ignores it.
- Reset during RD_*: read abandoned, no rvalid, back to IDLE.
- Simultaneous requests with starve_cnt = STARVE_MAX: the loader wins. EX stalls at least 1 cycle (write) or 2 cycles (read).
- Requesters hold addr/we/wdata stable while req=1 and not yet complete. Behaviour is undefined otherwise.

Decomposition:
- Shared package (dm_pkg): ADDR_W, DATA_W, and the state encoding localparams IDLE=2'd0, RD_EX=2'd1, RD_LD=2'd2.
- One natural sub-module, dm_starve_counter: saturating counter with inc/clr, outputting starve_cnt >= STARVE_MAX.
- Arbiter FSM and muxing stay in dm_arbiter.

Test Plan:
- Reset: hold RST_N=0 for 2 cycles with ex_req=1 → mem_we=0, ex_rvalid=0, ld_gnt=0, ex_stall=1. After release, IDLE.
- EX store: ex_req=1, ex_we=1, addr=10'h005, wdata=32'hDEADBEEF → same cycle mem_we=1, mem_addr=5, ex_stall=0. Next cycle mem_we=0.
- EX load: ex_req=1, ex_we=0, addr=5 (memory holds 32'hDEADBEEF) → cycle 0 ex_stall=1. Cycle 1 ex_rvalid=1, ex_rdata=32'hDEADBEEF, ex_stall=0.
- Contention/starvation: ld_req=1 (store, addr 7) and ex_req=1 with EX stores every cycle → EX granted for 4 cycles, starve_cnt reaches 4. Cycle 5 ld_gnt=1, mem_addr=7, ex_stall=1. Counter then 0.
- Loader read: ld_req=1, ld_we=0, addr=7 holding 32'h12345678 with ex_req=0 → ld_gnt=1, then next cycle ld_rvalid=1, ld_rdata=32'h12345678. An ex_req raised in that RD_LD cycle sees ex_stall=1.
- Reset mid-read: EX load issued, RST_N=0 in the RD_EX cycle → ex_rvalid stays 0 at that edge. The FSM returns to IDLE and the load reissues after release.

Source files
------------

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared widths, starvation limit and FSM encoding for the data-memory arbiter
package dm_pkg;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_EX = 2'd1,
    RD_LD = 2'd2
  } state_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - EX, loader and memory signal bundle around the data-memory arbiter
interface dm_arbiter_if;
  import dm_pkg::*;

  logic              ex_req;
  logic              ex_we;
  logic [ADDR_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_wdata;
  logic              ex_stall;
  logic              ex_rvalid;
  logic [DATA_W-1:0] ex_rdata;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  ex_req, ex_we, ex_addr, ex_wdata,
    output ex_stall, ex_rvalid, ex_rdata,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_gnt, ld_rvalid, ld_rdata,
    output mem_addr, mem_data, mem_we,
    input  mem_q
  );

  modport master (
    output ex_req, ex_we, ex_addr, ex_wdata,
    input  ex_stall, ex_rvalid, ex_rdata,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  mem_addr, mem_data, mem_we,
    output mem_q
  );

endinterface

// File: rtl/dm_starve_counter.sv
// rtl/dm_starve_counter.sv - saturating count of cycles the loader has waited without a grant
module dm_starve_counter #(
  parameter int MAX = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_starved
);

  localparam int CNT_W = $clog2(MAX + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt < CNT_W'(MAX))) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_starved = (r_cnt >= CNT_W'(MAX));

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - shares the registered-read data memory between EX and the loader
module dm_arbiter
  import dm_pkg::*;
(
  input logic        CLK,
  input logic        RST_N,
  dm_arbiter_if.slave bus
);

  state_t r_state;
  state_t w_next;
  logic   w_ex_win;
  logic   w_ld_win;
  logic   w_starved;

  dm_starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .i_inc     (bus.ld_req & ~w_ld_win),
    .i_clr     (w_ld_win),
    .o_starved (w_starved)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Everything is gated by RST_N so a read caught by reset never reports valid data.
  always_comb begin
    w_next        = IDLE;
    w_ex_win      = 1'b0;
    w_ld_win      = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_data  = '0;
    bus.mem_we    = 1'b0;
    bus.ld_gnt    = 1'b0;
    bus.ex_rvalid = 1'b0;
    bus.ex_rdata  = '0;
    bus.ld_rvalid = 1'b0;
    bus.ld_rdata  = '0;

    case (r_state)
      IDLE: begin
        if (RST_N) begin
          if (bus.ex_req && (!bus.ld_req || !w_starved)) begin
            w_ex_win = 1'b1;
          end else if (bus.ld_req) begin
            w_ld_win = 1'b1;
          end
        end
      end
      RD_EX: begin
        if (RST_N) begin
          bus.ex_rvalid = 1'b1;
          bus.ex_rdata  = bus.mem_q;
        end
      end
      RD_LD: begin
        if (RST_N) begin
          bus.ld_rvalid = 1'b1;
          bus.ld_rdata  = bus.mem_q;
        end
      end
      default: ;
    endcase

    if (w_ex_win) begin
      bus.mem_addr = bus.ex_addr;
      bus.mem_data = bus.ex_wdata;
      bus.mem_we   = bus.ex_we;
      if (!bus.ex_we) w_next = RD_EX;
    end
    if (w_ld_win) begin
      bus.mem_addr = bus.ld_addr;
      bus.mem_data = bus.ld_wdata;
      bus.mem_we   = bus.ld_we;
      bus.ld_gnt   = 1'b1;
      if (!bus.ld_we) w_next = RD_LD;
    end

    bus.ex_stall = bus.ex_req & ~(w_ex_win & bus.ex_we) & ~bus.ex_rvalid;
  end

endmodule
